// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the 36/18 sequential divider.
package div_pkg;

  localparam int unsigned DIVIDEND_W = 36;
  localparam int unsigned DIVISOR_W  = 18;
  localparam int unsigned ITER_CNT_W = 6;
  localparam int unsigned REM_W      = DIVISOR_W + 1;
  localparam int unsigned ITER_LAST  = DIVIDEND_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module seq_div_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);

  logic [REM_W:0] shifted;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? REM_W'(shifted - {2'b00, divisor}) : REM_W'(shifted);
  end

endmodule

// File: rtl/seq_divider_36x18.sv
// 36-by-18 sequential restoring divider, signed/unsigned, fixed 37-cycle latency.
module seq_divider_36x18
  import div_pkg::*;
#(
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic                  CLK0,
  input  logic                  RST0,
  input  logic                  START,
  input  logic                  SIGNEDD,
  input  logic [DIVIDEND_W-1:0] DIVIDEND,
  input  logic [DIVISOR_W-1:0]  DIVISOR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DIVIDEND_W-1:0] QUOTIENT,
  output logic [DIVISOR_W-1:0]  REMAINDER,
  output logic                  DIVZERO
);

  state_t                  state;
  state_t                  state_next;
  logic [ITER_CNT_W-1:0]   cnt;
  logic [REM_W-1:0]        rem;
  logic [DIVIDEND_W-1:0]   quo;
  logic [DIVISOR_W-1:0]    div_mag;
  logic [DIVISOR_W-1:0]    dvd_lo;
  logic                    neg_q;
  logic                    neg_r;
  logic                    dz;
  logic                    signed_mode;
  logic                    dvd_neg;
  logic                    dvs_neg;
  logic [REM_W-1:0]        step_rem;
  logic                    step_q;

  assign signed_mode = (SIGNED_EN != 0) && SIGNEDD;
  assign dvd_neg     = signed_mode & DIVIDEND[DIVIDEND_W-1];
  assign dvs_neg     = signed_mode & DIVISOR[DIVISOR_W-1];
  assign BUSY        = (state != IDLE);

  seq_div_step u_step (
    .rem_in       (rem),
    .dividend_bit (quo[DIVIDEND_W-1]),
    .divisor      (div_mag),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge CLK0) begin
    if (RST0) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // quo doubles as the dividend shift register: magnitude bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge CLK0) begin
    if (RST0) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      div_mag   <= '0;
      dvd_lo    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      DONE      <= 1'b0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      DIVZERO   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            cnt     <= ITER_CNT_W'(ITER_LAST);
            rem     <= '0;
            quo     <= dvd_neg ? -DIVIDEND : DIVIDEND;
            div_mag <= dvs_neg ? -DIVISOR : DIVISOR;
            dvd_lo  <= DIVIDEND[DIVISOR_W-1:0];
            neg_q   <= dvd_neg ^ dvs_neg;
            neg_r   <= dvd_neg;
            dz      <= (DIVISOR == '0);
          end
        end
        CALC: begin
          rem <= step_rem;
          quo <= {quo[DIVIDEND_W-2:0], step_q};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          DONE    <= 1'b1;
          DIVZERO <= dz;
          if (dz) begin
            QUOTIENT  <= '1;
            REMAINDER <= dvd_lo;
          end else begin
            QUOTIENT  <= neg_q ? -quo : quo;
            REMAINDER <= neg_r ? -rem[DIVISOR_W-1:0] : rem[DIVISOR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_36x18.sv
// Scoreboard bench for seq_divider_36x18: directed vectors, monitor checks each DONE.
module tb_seq_divider_36x18;

  logic        CLK0 = 1'b0;
  logic        RST0 = 1'b1;
  logic        START = 1'b0;
  logic        SIGNEDD = 1'b0;
  logic [35:0] DIVIDEND = '0;
  logic [17:0] DIVISOR = '0;
  logic        BUSY;
  logic        DONE;
  logic [35:0] QUOTIENT;
  logic [17:0] REMAINDER;
  logic        DIVZERO;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  typedef struct {
    logic [35:0] q;
    logic [17:0] r;
    logic        dz;
    int          k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  seq_divider_36x18 #(.SIGNED_EN(1)) dut (
    .CLK0      (CLK0),
    .RST0      (RST0),
    .START     (START),
    .SIGNEDD   (SIGNEDD),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .DIVZERO   (DIVZERO)
  );

  always #5 CLK0 = ~CLK0;
  always @(posedge CLK0) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK0) begin
    if (DONE === 1'b1) begin
      if (sb.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL unexpected_done: got DONE=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient",  64'(QUOTIENT),  64'(mon_e.q));
        check("remainder", 64'(REMAINDER), 64'(mon_e.r));
        check("divzero",   64'(DIVZERO),   64'(mon_e.dz));
        check("latency",   64'(cyc),       64'(mon_e.k + 37));
      end
    end
  end

  // Called at a negedge; START is sampled at the following rising edge (edge k).
  task automatic start_op(input logic [35:0] dvd, input logic [17:0] dvs, input logic sgn,
                          input logic [35:0] eq, input logic [17:0] er, input logic edz);
    exp_t e;
    START    = 1'b1;
    DIVIDEND = dvd;
    DIVISOR  = dvs;
    SIGNEDD  = sgn;
    e.q = eq; e.r = er; e.dz = edz; e.k = cyc + 1;
    sb.push_back(e);
    @(negedge CLK0);
    START = 1'b0;
    check("busy_after_start", 64'(BUSY), 64'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK0);
      if (DONE === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      asserts++;
      fails++;
      $display("FAIL done_timeout: got no DONE expected DONE within 60 cycles");
    end else begin
      check("busy_at_done", 64'(BUSY), 64'd0);
    end
  endtask

  typedef struct {
    logic [35:0] dvd;
    logic [17:0] dvs;
    logic        sgn;
    logic [35:0] q;
    logic [17:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{36'd1000,       18'd7,       1'b0, 36'd142,       18'd6,       1'b0};
    vecs[1] = '{36'hFFFFFFF9C,  18'h00007,   1'b1, 36'hFFFFFFFF2, 18'h3FFFE,   1'b0};
    vecs[2] = '{36'hFFFFFFFFF,  18'h3FFFF,   1'b0, 36'h000040001, 18'h00000,   1'b0};
    vecs[3] = '{36'h000012345,  18'h00000,   1'b0, 36'hFFFFFFFFF, 18'h12345,   1'b1};
    vecs[4] = '{36'd100,        18'h3FFF9,   1'b1, 36'hFFFFFFFF2, 18'd2,       1'b0};
    vecs[5] = '{36'hFFFFFFF9C,  18'h3FFF9,   1'b1, 36'd14,        18'h3FFFE,   1'b0};

    repeat (3) @(negedge CLK0);
    check("rst_busy",      64'(BUSY),      64'd0);
    check("rst_done",      64'(DONE),      64'd0);
    check("rst_quotient",  64'(QUOTIENT),  64'd0);
    check("rst_remainder", 64'(REMAINDER), 64'd0);
    check("rst_divzero",   64'(DIVZERO),   64'd0);
    RST0 = 1'b0;
    @(negedge CLK0);

    foreach (vecs[i]) begin
      start_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, vecs[i].q, vecs[i].r, vecs[i].dz);
      wait_done();
      @(negedge CLK0);
    end

    // START during an operation must not disturb it
    start_op(36'd12345, 18'd100, 1'b0, 36'd123, 18'd45, 1'b0);
    repeat (4) @(negedge CLK0);
    START = 1'b1; DIVIDEND = 36'd5; DIVISOR = 18'd1; SIGNEDD = 1'b0;
    @(negedge CLK0);
    START = 1'b0;
    check("busy_ignore_start", 64'(BUSY), 64'd1);
    wait_done();
    repeat (5) @(negedge CLK0);
    check("hold_quotient",  64'(QUOTIENT),  64'd123);
    check("hold_remainder", 64'(REMAINDER), 64'd45);
    check("hold_divzero",   64'(DIVZERO),   64'd0);

    // reset at k+10 aborts the operation with no DONE
    start_op(36'd1000, 18'd7, 1'b0, 36'd142, 18'd6, 1'b0);
    repeat (9) @(negedge CLK0);
    RST0 = 1'b1;
    sb.delete();
    @(negedge CLK0);
    check("abort_busy",      64'(BUSY),      64'd0);
    check("abort_done",      64'(DONE),      64'd0);
    check("abort_quotient",  64'(QUOTIENT),  64'd0);
    check("abort_remainder", 64'(REMAINDER), 64'd0);
    check("abort_divzero",   64'(DIVZERO),   64'd0);
    RST0 = 1'b0;
    repeat (45) @(negedge CLK0);

    // back-to-back: second START issued in the DONE cycle of the first
    start_op(36'h800000000, 18'h3FFFF, 1'b1, 36'h800000000, 18'h00000, 1'b0);
    wait_done();
    start_op(36'd7, 18'h3FFFE, 1'b1, 36'hFFFFFFFFD, 18'd1, 1'b0);
    wait_done();
    repeat (3) @(negedge CLK0);

    if (sb.size() != 0) begin
      asserts++;
      fails++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_divider_36x18.md
SEQ_DIVIDER_36X18 -- requirements
Module: seq_divider_36x18

Interface
REQ-001 SHALL have parameter SIGNED_EN, default 1, where 1 enables the SIGNEDD input and 0 ties signed mode off.
REQ-002 SHALL have port CLK0, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST0, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port START, input, 1 bit: operation request, sampled only while BUSY=0.
REQ-005 SHALL have port SIGNEDD, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; captured with START.
REQ-006 SHALL have port DIVIDEND, input, 36 bits: numerator, captured with START.
REQ-007 SHALL have port DIVISOR, input, 18 bits: denominator, captured with START.
REQ-008 SHALL have port BUSY, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-010 SHALL have port QUOTIENT, output, 36 bits: registered quotient, held until the next DONE.
REQ-011 SHALL have port REMAINDER, output, 18 bits: registered remainder, held until the next DONE.
REQ-012 SHALL have port DIVZERO, output, 1 bit: divide-by-zero flag, updated with DONE.

Function
REQ-013 SHALL implement the FSM IDLE -> CALC -> FIX -> IDLE.
  - IDLE -> CALC on START=1.
  - CALC -> FIX after 36 iterations.
  - FIX -> IDLE unconditionally.
REQ-014 SHALL, when START=1 with BUSY=0 at edge k, capture operands, load a 6-bit iteration counter with 35, and assert BUSY from edge k.
REQ-015 SHALL perform one restoring-division iteration per cycle in CALC (edges k+1..k+36) on operand magnitudes, using a 19-bit partial remainder.
REQ-016 SHALL, at edge k+37 (FIX):
  - apply sign correction;
  - register QUOTIENT, REMAINDER and DIVZERO;
  - pulse DONE=1 for exactly one cycle;
  - drop BUSY=0.
  Latency SHALL be a constant 37 cycles for all operand values.
REQ-017 SHALL apply signed-mode results as follows:
  - quotient sign = sign(DIVIDEND) XOR sign(DIVISOR);
  - remainder takes the sign of DIVIDEND (truncating division);
  - DIVIDEND = 0x800000000 with DIVISOR = 0x3FFFF gives QUOTIENT = 0x800000000 (wraps) and REMAINDER = 0.
REQ-018 SHALL, when DIVISOR=0, set DIVZERO=1, QUOTIENT=0xFFFFFFFFF and REMAINDER=DIVIDEND[17:0], with unchanged latency.
REQ-019 SHALL ignore START while BUSY=1; in-flight operands and timing SHALL NOT be affected.
REQ-020 SHALL accept START in the same cycle that DONE is high (back-to-back operation), since BUSY=0 then.
REQ-021 SHALL keep QUOTIENT, REMAINDER and DIVZERO stable between DONE pulses.

Reset
REQ-022 SHALL, on RST0=1 at a rising edge:
  - force state to IDLE;
  - set BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIVZERO=0;
  - clear the counter and partial remainder.
REQ-023 SHALL abort any in-flight operation when RST0 is asserted mid-operation, with no DONE pulse produced for it.
REQ-024 SHALL give RST0 priority over START in the same cycle.

Structure
REQ-025 SHALL place the following constants and types in the shared package div_pkg:
  - DIVIDEND_W=36, DIVISOR_W=18, ITER_CNT_W=6;
  - state enum {IDLE, CALC, FIX}.
REQ-026 SHALL implement one iteration as combinational sub-module seq_div_step.
  - Inputs: 19-bit partial remainder, next dividend bit, 18-bit divisor magnitude.
  - Outputs: new partial remainder, quotient bit.

Verification
REQ-027 SHALL cover unsigned 1000/7 (SIGNEDD=0, START at edge k) -> QUOTIENT=142, REMAINDER=6, DIVZERO=0, DONE only at edge k+37.
REQ-028 SHALL cover signed -100/7 (DIVIDEND=0xFFFFFFF9C, DIVISOR=0x00007) -> QUOTIENT=0xFFFFFFFF2, REMAINDER=0x3FFFE.
REQ-029 SHALL cover unsigned 0xFFFFFFFFF/0x3FFFF -> QUOTIENT=0x000040001, REMAINDER=0.
REQ-030 SHALL cover divide-by-zero (DIVIDEND=0x000012345, DIVISOR=0) -> DIVZERO=1, QUOTIENT=0xFFFFFFFFF, REMAINDER=0x12345, latency 37.
REQ-031 SHALL cover START pulsed at k+5 during an operation -> ignored, first result intact; then RST0 at k+10 of a new operation -> next cycle all outputs 0, no DONE.
REQ-032 SHALL cover back-to-back operation (START with DONE) and signed 0x800000000/0x3FFFF -> QUOTIENT=0x800000000, REMAINDER=0.
